// File: rtl/hls_activity_monitor.sv
// hls_activity_monitor
// Watches one HLS block's ap_start/ap_ready/ap_done/ap_continue handshake and
// the ap_CS_fsm state of one sequential loop. It accumulates saturating
// transaction, latency, iteration and trip-count statistics. The counters are
// read once finish has frozen them.
//
// Parameters: STATE_W (one-hot state width), CNT_W (counter width).
// Inputs : clock, reset (sync, active-high), ap_start, ap_ready, ap_done,
//          ap_continue, cur_state, iter_start_state, iter_end_state,
//          exit_state, stall, finish.
// Outputs: busy, txn_count, ready_count, last_latency, max_latency,
//          busy_cycles, iter_count, loop_count, last_trip_count,
//          loop_active, overflow, frozen.
//
// Build option: define HLS_MON_MAX_LAT_EN to keep the max_latency register
// and comparator; without it max_latency is tied to 0.
module hls_activity_monitor #(
  parameter int unsigned STATE_W = 15,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] exit_state,
  input  logic               stall,
  input  logic               finish,
  output logic               busy,
  output logic [CNT_W-1:0]   txn_count,
  output logic [CNT_W-1:0]   ready_count,
  output logic [CNT_W-1:0]   last_latency,
  output logic [CNT_W-1:0]   max_latency,
  output logic [CNT_W-1:0]   busy_cycles,
  output logic [CNT_W-1:0]   iter_count,
  output logic [CNT_W-1:0]   loop_count,
  output logic [CNT_W-1:0]   last_trip_count,
  output logic               loop_active,
  output logic               overflow,
  output logic               frozen
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == ONES) ? v : v + ONE;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] trip_q, trip_d;
  logic [CNT_W-1:0] txn_d, ready_d, last_lat_d, busy_cyc_d;
  logic [CNT_W-1:0] iter_d, loop_cnt_d, last_trip_d;
  logic [CNT_W-1:0] cur_lat, trip_base;
  logic             active_d, ovf_hit, close;
  logic             m_start, m_end, m_exit, enter;

`ifdef HLS_MON_MAX_LAT_EN
  logic [CNT_W-1:0] max_q, max_d;
  assign max_latency = max_q;
`else
  assign max_latency = '0;
`endif

  assign busy = (state_q == BUSY);

  assign m_start = (cur_state == iter_start_state) && !stall;
  assign m_end   = (cur_state == iter_end_state)   && !stall;
  assign m_exit  = (cur_state == exit_state)       && !stall;
  assign enter   = !loop_active && m_start;

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    trip_d      = trip_q;
    txn_d       = txn_count;
    ready_d     = ready_count;
    last_lat_d  = last_latency;
    busy_cyc_d  = busy_cycles;
    iter_d      = iter_count;
    loop_cnt_d  = loop_count;
    last_trip_d = last_trip_count;
    active_d    = loop_active;
    ovf_hit     = 1'b0;
    close       = 1'b0;
    cur_lat     = '0;
    trip_base   = '0;
`ifdef HLS_MON_MAX_LAT_EN
    max_d       = max_q;
`endif

    // cur_lat is the inclusive latency of the current cycle; a close uses it
    // directly, otherwise it becomes the stored count for the next cycle.
    if (state_q == IDLE) begin
      if (ap_start) begin
        cur_lat = ONE;
        if (ap_done && ap_continue) begin
          close = 1'b1;
        end else begin
          state_d = BUSY;
          lat_d   = cur_lat;
        end
      end
    end else begin
      cur_lat = sat_inc(lat_q);
      ovf_hit = ovf_hit | (lat_q == ONES);
      if (ap_done && ap_continue) begin
        close   = 1'b1;
        state_d = IDLE;
      end else begin
        lat_d = cur_lat;
      end
    end

    if (close) begin
      txn_d      = sat_inc(txn_count);
      ovf_hit    = ovf_hit | (txn_count == ONES);
      last_lat_d = cur_lat;
`ifdef HLS_MON_MAX_LAT_EN
      if (cur_lat > max_q) max_d = cur_lat;
`endif
    end

    if (ap_start && ap_ready) begin
      ready_d = sat_inc(ready_count);
      ovf_hit = ovf_hit | (ready_count == ONES);
    end

    if (state_q == BUSY) begin
      busy_cyc_d = sat_inc(busy_cycles);
      ovf_hit    = ovf_hit | (busy_cycles == ONES);
    end

    // Exit wins over an iteration end in the same cycle. On entry the trip
    // counter restarts from 0 even if that cycle also ends an iteration.
    if (loop_active && m_exit) begin
      active_d    = 1'b0;
      last_trip_d = trip_q;
    end else begin
      if (enter) begin
        active_d   = 1'b1;
        loop_cnt_d = sat_inc(loop_count);
        ovf_hit    = ovf_hit | (loop_count == ONES);
        trip_d     = '0;
      end
      if (m_end && (loop_active || enter)) begin
        trip_base = enter ? '0 : trip_q;
        iter_d    = sat_inc(iter_count);
        trip_d    = sat_inc(trip_base);
        ovf_hit   = ovf_hit | (iter_count == ONES) | (trip_base == ONES);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      lat_q           <= '0;
      trip_q          <= '0;
      txn_count       <= '0;
      ready_count     <= '0;
      last_latency    <= '0;
      busy_cycles     <= '0;
      iter_count      <= '0;
      loop_count      <= '0;
      last_trip_count <= '0;
      loop_active     <= 1'b0;
      overflow        <= 1'b0;
      frozen          <= 1'b0;
`ifdef HLS_MON_MAX_LAT_EN
      max_q           <= '0;
`endif
    end else begin
      if (finish) frozen <= 1'b1;
      if (!frozen && !finish) begin
        state_q         <= state_d;
        lat_q           <= lat_d;
        trip_q          <= trip_d;
        txn_count       <= txn_d;
        ready_count     <= ready_d;
        last_latency    <= last_lat_d;
        busy_cycles     <= busy_cyc_d;
        iter_count      <= iter_d;
        loop_count      <= loop_cnt_d;
        last_trip_count <= last_trip_d;
        loop_active     <= active_d;
        overflow        <= overflow | ovf_hit;
`ifdef HLS_MON_MAX_LAT_EN
        max_q           <= max_d;
`endif
      end
    end
  end

endmodule

// File: tb/tb_hls_activity_monitor.sv
// Self-checking bench for hls_activity_monitor: a 32-bit instance for
// functional checks and a 4-bit instance sharing the same inputs for
// saturation.
module tb_hls_activity_monitor;

  localparam int unsigned SW = 15;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, ap_start, ap_ready, ap_done, ap_continue, stall, finish;
  logic [SW-1:0] cur_state, iter_start_state, iter_end_state, exit_state;

  logic        busy, loop_active, overflow, frozen;
  logic [31:0] txn_count, ready_count, last_latency, max_latency, busy_cycles;
  logic [31:0] iter_count, loop_count, last_trip_count;

  logic       busy4, loop_active4, overflow4, frozen4;
  logic [3:0] txn4, ready4, last_lat4, max_lat4, busy_cyc4;
  logic [3:0] iter4, loop4, last_trip4;

  hls_activity_monitor #(.STATE_W(SW), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .cur_state(cur_state),
    .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
    .exit_state(exit_state), .stall(stall), .finish(finish),
    .busy(busy), .txn_count(txn_count), .ready_count(ready_count),
    .last_latency(last_latency), .max_latency(max_latency),
    .busy_cycles(busy_cycles), .iter_count(iter_count),
    .loop_count(loop_count), .last_trip_count(last_trip_count),
    .loop_active(loop_active), .overflow(overflow), .frozen(frozen)
  );

  hls_activity_monitor #(.STATE_W(SW), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .cur_state(cur_state),
    .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
    .exit_state(exit_state), .stall(stall), .finish(finish),
    .busy(busy4), .txn_count(txn4), .ready_count(ready4),
    .last_latency(last_lat4), .max_latency(max_lat4),
    .busy_cycles(busy_cyc4), .iter_count(iter4),
    .loop_count(loop4), .last_trip_count(last_trip4),
    .loop_active(loop_active4), .overflow(overflow4), .frozen(frozen4)
  );

  typedef struct {
    int unsigned dly;      // cycles from start to done+continue
    int unsigned held;     // trailing cycles of done without continue
    bit          pulse;    // ap_start pulses while busy
    int unsigned lat;      // expected inclusive latency
    int unsigned busy_add; // expected busy_cycles increment
  } txn_vec_t;

  typedef struct {
    int unsigned lat;
    int unsigned txn;
    int unsigned mx;
    int unsigned bc;
  } exp_t;

  txn_vec_t vecs[6];
  exp_t     sb[$];

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [SW-1:0] st(input int unsigned n);
    logic [SW-1:0] v;
    v    = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic idle_inputs();
    ap_start    = 1'b0;
    ap_ready    = 1'b0;
    ap_done     = 1'b0;
    ap_continue = 1'b0;
    stall       = 1'b0;
  endtask

  task automatic drive_txn(input txn_vec_t v);
    ap_start = 1'b1;
    if (v.dly == 0) begin
      ap_done     = 1'b1;
      ap_continue = 1'b1;
    end
    step();
    chk("busy_after_start", 32'(busy), (v.dly == 0) ? 32'd0 : 32'd1);
    for (int unsigned c = 1; c <= v.dly; c++) begin
      ap_start = v.pulse && (c % 2 == 1) && (c < v.dly);
      if (c == v.dly) begin
        ap_done = 1'b1; ap_continue = 1'b1;
      end else if (c + v.held >= v.dly) begin
        ap_done = 1'b1; ap_continue = 1'b0;
      end else begin
        ap_done = 1'b0; ap_continue = 1'b0;
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    int unsigned exp_txn, exp_max, exp_bc, mx;
    exp_t e;

    vecs[0] = '{dly: 4, held: 0, pulse: 1'b0, lat: 5, busy_add: 4};
    vecs[1] = '{dly: 0, held: 0, pulse: 1'b0, lat: 1, busy_add: 0};
    vecs[2] = '{dly: 0, held: 0, pulse: 1'b0, lat: 1, busy_add: 0};
    vecs[3] = '{dly: 0, held: 0, pulse: 1'b0, lat: 1, busy_add: 0};
    vecs[4] = '{dly: 5, held: 3, pulse: 1'b1, lat: 6, busy_add: 5};
    vecs[5] = '{dly: 1, held: 0, pulse: 1'b0, lat: 2, busy_add: 1};

    idle_inputs();
    finish           = 1'b0;
    cur_state        = '0;
    iter_start_state = st(4);
    iter_end_state   = st(14);
    exit_state       = st(1);
    reset            = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_txn", txn_count, 32'd0);
    chk("rst_last_lat", last_latency, 32'd0);
    chk("rst_loop_active", 32'(loop_active), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frozen", 32'(frozen), 32'd0);

    // Transaction table through the scoreboard
    exp_txn = 0; exp_max = 0; exp_bc = 0;
    for (int i = 0; i < 6; i++) begin
      exp_txn++;
      if (vecs[i].lat > exp_max) exp_max = vecs[i].lat;
      exp_bc += vecs[i].busy_add;
`ifdef HLS_MON_MAX_LAT_EN
      mx = exp_max;
`else
      mx = 0;
`endif
      sb.push_back('{lat: vecs[i].lat, txn: exp_txn, mx: mx, bc: exp_bc});
      drive_txn(vecs[i]);
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_last_latency", i), last_latency, e.lat);
        chk($sformatf("v%0d_txn_count", i), txn_count, e.txn);
        chk($sformatf("v%0d_max_latency", i), max_latency, e.mx);
        chk($sformatf("v%0d_busy_cycles", i), busy_cycles, e.bc);
        chk($sformatf("v%0d_busy_closed", i), 32'(busy), 32'd0);
      end
      step();
    end
    chk("ready_none", ready_count, 32'd0);

    // ap_done in IDLE without ap_start is ignored
    ap_done = 1'b1; ap_continue = 1'b1;
    step();
    idle_inputs();
    chk("idle_done_txn", txn_count, 32'd6);
    chk("idle_done_busy", 32'(busy), 32'd0);

    // ready counting with a same-cycle transaction
    ap_start = 1'b1; ap_ready = 1'b1; ap_done = 1'b1; ap_continue = 1'b1;
    step();
    idle_inputs();
    chk("ready_count", ready_count, 32'd1);
    chk("ready_txn", txn_count, 32'd7);

    // Loop: exit while inactive is ignored
    cur_state = st(1);
    step();
    chk("exit_inactive_active", 32'(loop_active), 32'd0);
    chk("exit_inactive_loops", loop_count, 32'd0);

    // 10 iterations, some state14 cycles stalled
    for (int it = 0; it < 10; it++) begin
      cur_state = st(4);
      step();
      if (it == 0) begin
        chk("loop_enter_active", 32'(loop_active), 32'd1);
        chk("loop_enter_count", loop_count, 32'd1);
      end
      cur_state = st(8);
      step();
      if (it % 3 == 1) begin
        cur_state = st(14); stall = 1'b1;
        step();
        stall = 1'b0;
      end
      cur_state = st(14);
      step();
    end
    chk("loop1_iter_pre_exit", iter_count, 32'd10);
    cur_state = st(1);
    step();
    chk("loop1_active", 32'(loop_active), 32'd0);
    chk("loop1_count", loop_count, 32'd1);
    chk("loop1_iter", iter_count, 32'd10);
    chk("loop1_trip", last_trip_count, 32'd10);

    // Second entry, 2 iterations, stalled exit first
    for (int it = 0; it < 2; it++) begin
      cur_state = st(4);  step();
      cur_state = st(14); step();
    end
    cur_state = st(1); stall = 1'b1;
    step();
    stall = 1'b0;
    chk("loop2_stalled_exit", 32'(loop_active), 32'd1);
    step();
    chk("loop2_count", loop_count, 32'd2);
    chk("loop2_trip", last_trip_count, 32'd2);
    chk("loop2_iter", iter_count, 32'd12);

    // Single-state loop
    iter_start_state = st(6);
    iter_end_state   = st(6);
    cur_state = st(6);
    step();
    chk("single_enter_count", loop_count, 32'd3);
    chk("single_enter_iter", iter_count, 32'd13);
    step();
    chk("single_iter2", iter_count, 32'd14);
    cur_state = st(1);
    step();
    chk("single_trip", last_trip_count, 32'd2);
    chk("single_inactive", 32'(loop_active), 32'd0);
    cur_state = '0;

    // Saturation on the 4-bit instance
    reset = 1'b1; step(); reset = 1'b0;
    ap_start = 1'b1; ap_done = 1'b1; ap_continue = 1'b1;
    for (int k = 0; k < 15; k++) step();
    chk("sat_txn15", 32'(txn4), 32'd15);
    chk("sat_no_ovf_yet", 32'(overflow4), 32'd0);
    step();
    step();
    idle_inputs();
    chk("sat_txn_hold", 32'(txn4), 32'd15);
    chk("sat_overflow", 32'(overflow4), 32'd1);
    chk("wide_txn17", txn_count, 32'd17);
    chk("wide_no_overflow", 32'(overflow), 32'd0);
    chk("sat_last_lat", 32'(last_lat4), 32'd1);
`ifdef HLS_MON_MAX_LAT_EN
    chk("sat_max_lat", 32'(max_lat4), 32'd1);
`else
    chk("sat_max_lat", 32'(max_lat4), 32'd0);
`endif

    // Freeze mid-transaction, then reset overrides finish
    reset = 1'b1; step(); reset = 1'b0;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    chk("frz_busy_open", 32'(busy), 32'd1);
    step();
    chk("frz_bc_before", busy_cycles, 32'd1);
    finish = 1'b1;
    step();
    chk("frz_frozen", 32'(frozen), 32'd1);
    chk("frz_first_edge_bc", busy_cycles, 32'd1);
    ap_done = 1'b1; ap_continue = 1'b1;
    cur_state = st(6);
    step();
    step();
    chk("frz_txn", txn_count, 32'd0);
    chk("frz_busy", 32'(busy), 32'd1);
    chk("frz_bc", busy_cycles, 32'd1);
    chk("frz_last_lat", last_latency, 32'd0);
    chk("frz_loop_active", 32'(loop_active), 32'd0);
    chk("frz_iter", iter_count, 32'd0);
    reset = 1'b1;
    step();
    chk("rst2_frozen", 32'(frozen), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_bc", busy_cycles, 32'd0);
    reset = 1'b0; finish = 1'b0; cur_state = '0;
    idle_inputs();
    step();
    chk("rst2_idle_txn", txn_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
